mult_share_sched: RTL
=====================

// Module: mult_share_sched
// PURPOSE
// Scheduler that shares one shift-add multiplier datapath between NREQ requesters.
// Sits between the requester ports and the multiplier datapath.
// Arbitrates round-robin, steers the winner's operands with a one-hot Grant, and sequences the datapath.
// Uses an iteration counter rather than unrolled states, so operand width is a parameter.
// PARAMETERS
// WIDTH  8  operand width; number of add/shift iterations per multiply (>=2)
// NREQ   2  number of requesters (>=2)
// PORTS
// Clk      in   1      clock; all state changes on posedge
// Reset    in   1      asynchronous, active-low reset
// Req      in   NREQ   per-requester level request; held until matching Done seen
// Grant    out  NREQ   one-hot owner of datapath (operand mux select); 0 when idle
// Done     out  NREQ   one-cycle pulse to owner when product is valid
// Busy     out  1      1 in every state except IDLE
// goToB    out  1      datapath: clear A, load B from granted operand
// Add      out  1      datapath: conditional add of S into A (on M bit)
// Sub      out  1      datapath: with Add, subtract instead (sign step)
// Shift    out  1      datapath: arithmetic right shift of A:B
// BEHAVIOUR
// - Reset (Reset=0, async): state=IDLE, iteration counter=0, RR pointer=0; all outputs 0.
// - States: IDLE, LOAD, ADD, SHIFT, DONE, RELEASE.
// - IDLE: if any Req, the RR arbiter picks the first set bit at or after the pointer, wrapping.
//   Owner is latched; next state is LOAD. If no Req, remain in IDLE.
// - LOAD (1 cycle): goToB=1; counter cleared to 0; next state is ADD.
// - ADD: Add=1; Sub=1 only when counter==WIDTH-1; next state is SHIFT.
// - SHIFT: Shift=1; counter increments.
//   If the pre-increment counter==WIDTH-1, next state is DONE; otherwise next state is ADD.
// - DONE (1 cycle): Done[owner]=1; RR pointer moves to owner+1 mod NREQ; next state is RELEASE.
// - RELEASE: remain until Req[owner]==0, then go to IDLE. This prevents the same request being granted twice.
// - Grant is registered. It equals onehot(owner) from LOAD through RELEASE inclusive, and is 0 in IDLE.
// - Control outputs (goToB, Add, Sub, Shift) are a decode of the current state only; at most one of goToB/Add/Shift is high.
// - Latency: Req is sampled in IDLE at cycle t. LOAD at t+1; ADD/SHIFT span t+2..t+2*WIDTH+1; Done at t+2*WIDTH+2.
//   For WIDTH=8, Done is at t+18.
// - Exactly WIDTH Add pulses, WIDTH Shift pulses and 1 Sub pulse occur per operation.
// - Req changes after a grant are ignored until RELEASE. Dropping Req mid-operation does not abort; Done still fires.
// - Simultaneous requests: one grant per operation. Others wait in IDLE arbitration without starvation.
//   Worst-case wait is (NREQ-1) operations.
// - Reset asserted mid-operation: immediate IDLE and all outputs 0. The partial product is abandoned and no Done is issued.
// - Counter width is $clog2(WIDTH); it never wraps inside an operation.
// STRUCTURE
// - Package mult_ctl_pkg holds:
//   - the state enum type sched_state_t (IDLE, LOAD, ADD, SHIFT, DONE, RELEASE);
//   - the default constants MULT_WIDTH=8 and MULT_NREQ=2.
// - Sub-module rr_arbiter (parameter NREQ): combinational.
//   Inputs are Req and pointer; outputs are a one-hot winner and a valid flag.
//   The pointer register stays in the parent.
// - Parent: two-process FSM (always_ff with async reset, always_comb for next state and decode), plus the counter and owner registers.
// TESTING
// - Single Req[0] pulse-held, WIDTH=8:
//   Grant=01 at t+1, goToB at t+1; 8 Add, 8 Shift, Sub only with the 8th Add; Done=01 at t+18; Busy low after Req drops.
// - Req=11 asserted together from reset:
//   requester 0 is served first (Done[0]); requester 1 is granted in the next IDLE; the third operation goes back to requester 0.
// - Req[1] held high for 5 cycles after Done[1]:
//   FSM stays in RELEASE; no second LOAD; IDLE is entered the cycle after Req[1] falls.
// - Req[0] deasserted at the 3rd Shift:
//   the operation still completes and Done[0] pulses at t+18.
// - Reset driven low during the 5th Add:
//   all outputs 0 immediately (async); on release, Req=10 is granted to requester 1 (pointer=0, req0 absent).
// - Instantiate with WIDTH=4, NREQ=3 and Req=111:
//   Done at t+10 per operation; grant order 0,1,2,0.

Source files
------------

// File: rtl/mult_ctl_pkg.sv
// Shared types and default sizing for the shared-multiplier scheduler.
`default_nettype none

package mult_ctl_pkg;
  localparam int MULT_WIDTH = 8;
  localparam int MULT_NREQ  = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    ADD     = 3'd2,
    SHIFT   = 3'd3,
    DONE    = 3'd4,
    RELEASE = 3'd5
  } sched_state_t;
endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
`default_nettype none

module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic                    valid
);

  // Outer loop walks priority order starting at ptr; inner loop keeps indices constant.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!valid && req[j] && (((int'(ptr) + i) % NREQ) == j)) begin
          grant[j] = 1'b1;
          valid    = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mult_share_sched.sv
// Shares one shift-add multiplier datapath between NREQ requesters and sequences it.
`default_nettype none

module mult_share_sched
  import mult_ctl_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int NREQ  = MULT_NREQ
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [NREQ-1:0] Req,
  output logic [NREQ-1:0] Grant,
  output logic [NREQ-1:0] Done,
  output logic            Busy,
  output logic            goToB,
  output logic            Add,
  output logic            Sub,
  output logic            Shift
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = $clog2(NREQ);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [PW-1:0] OWN_LAST = PW'(NREQ - 1);

  sched_state_t    state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] arb_grant;
  logic            arb_valid;
  logic [PW-1:0]   arb_idx;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (Req),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  always_comb begin
    arb_idx = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (arb_grant[j]) arb_idx = PW'(j);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          owner_d = arb_idx;
          grant_d = arb_grant;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = ADD;
      end
      ADD: state_d = SHIFT;
      SHIFT: begin
        // Last iteration parks the counter at 0 instead of wrapping past WIDTH-1.
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ADD;
        end
      end
      DONE: begin
        ptr_d   = (owner_q == OWN_LAST) ? '0 : owner_q + 1'b1;
        state_d = RELEASE;
      end
      RELEASE: begin
        // Wait for the owner to drop its level request so it is not served twice.
        if (!(|(Req & grant_q))) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  assign Grant = grant_q;
  assign Busy  = (state_q != IDLE);
  assign goToB = (state_q == LOAD);
  assign Add   = (state_q == ADD);
  assign Sub   = (state_q == ADD) && (cnt_q == CNT_LAST);
  assign Shift = (state_q == SHIFT);
  assign Done  = (state_q == DONE) ? grant_q : '0;

endmodule

`default_nettype wire
